load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage between the execute stage and `datamemory` (32-bit word, 10-bit word address, single `cs`/`WR_RD` port, no byte enables). Takes one MIPS load/store request at a time, converts byte addresses to word addresses, and implements sub-word stores as read-modify-write. Returns sign- or zero-extended load data, or a misalignment flag, through a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 10, `datamemory` word-address width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle; request accepted on an edge where `req_valid && req_ready`
- `op`  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
- `addr`  in  32  byte address; only `addr[ADDR_WIDTH+1:0]` used, upper bits ignored
- `wdata`  in  32  store data; SB uses `[7:0]`, SH uses `[15:0]`
- `resp_valid`  out  1  one-cycle completion pulse
- `rdata`  out  32  load result; held until the next load response
- `misaligned`  out  1  qualifies `resp_valid`; access was not performed
- `mem_cs`  out  1  to `datamemory` `cs`
- `mem_we`  out  1  to `datamemory` `WR_RD`; 1 = write
- `mem_addr`  out  ADDR_WIDTH  word address = `addr[ADDR_WIDTH+1:2]`
- `mem_din`  out  32  write data to memory
- `mem_dout`  in  32  read data from memory; valid the cycle after a read cycle (cs=1, we=0)

## Operation
- Byte order is big-endian. Offset 0 maps to bits [31:24], offset 3 to [7:0]. A halfword at offset 0 is [31:16]; at offset 2 it is [15:0].
- Misaligned cases: LH, LHU and SH with `addr[0]=1`; LW and SW with `addr[1:0]≠0`. A misaligned request produces no memory cycle and goes straight to RESP with `misaligned=1`. `rdata` is unchanged.
- FSM states:
  - IDLE: `req_ready=1`. On acceptance, latch op, addr and wdata. Next state is RESP if misaligned, WR for SW, otherwise RD.
  - RD: `mem_cs=1`, `mem_we=0`. Next state is RWAIT.
  - RWAIT: sample `mem_dout`.
    - For a load: extract the byte or half, sign-extend (LB, LH) or zero-extend (LBU, LHU), register into `rdata`. Next state is RESP.
    - For SB or SH: merge the `wdata` lane into the read word, register it into `mem_din`. Next state is WR.
  - WR: `mem_cs=1`, `mem_we=1`, `mem_addr` held. Next state is RESP.
  - RESP: `resp_valid=1` for exactly one cycle. Next state is IDLE.
- `mem_cs=0` and `mem_we=0` in IDLE, RWAIT and RESP.
- `mem_addr` and `mem_din` are driven from latched registers and stay stable across RD→RWAIT→WR.
- At most one request is in flight. `req_ready=0` in every state except IDLE.

## Timing
- Latency is counted from the acceptance edge (cycle 0). `resp_valid` is high during:
  - load: cycle 3
  - SW: cycle 2
  - SB/SH: cycle 4
  - misaligned: cycle 1
- Back-to-back throughput: a new request can be accepted the cycle after RESP.
- Reset (`rst=1` sampled on an edge):
  - state goes to IDLE
  - `req_ready=0` while `rst` is high
  - `resp_valid`, `misaligned`, `mem_cs`, `mem_we` go to 0
  - `rdata`, `mem_addr`, `mem_din` go to 0
- Reset mid-operation aborts the access.
  - An RMW reset before WR never writes memory.
  - A write already issued in WR is not undone.
  - No `resp_valid` is produced for the aborted request.
- `req_valid` asserted during reset, or while not ready, is ignored; the requester holds it until accepted.

## Structure
- Package `ls_pkg`:
  - op encoding constants
  - FSM state enum {IDLE, RD, RWAIT, WR, RESP}
  - `DATA_WIDTH` and `ADDR_WIDTH` defaults
  - `is_store` / `is_misaligned` functions
- Sub-module `ls_align` (combinational):
  - load extract/extend: word, offset, op → rdata
  - store merge: word, wdata, offset, op → merged word
- The FSM, latches and memory-port registers live in `load_store_unit`.

## Test plan
- **LW:** memory word 5 = 0x8899AABB; LW addr 0x14 → `mem_cs=1`, `mem_we=0`, `mem_addr=5` in cycle 1; `resp_valid` in cycle 3; `rdata=0x8899AABB`, `misaligned=0`.
- **Sub-word loads:** same word; LB addr 0x15 → `rdata=0xFFFFFF99`; LBU 0x15 → `0x00000099`; LH 0x16 → `0xFFFFAABB`; LHU 0x14 → `0x00008899`.
- **SB RMW:** word 3 = 0x11223344; SB addr 0x0E, wdata 0x000000EE → read cycle 1, write cycle 3 with `mem_din=0x1122EE44`; `resp_valid` cycle 4; a following LW 0x0C returns 0x1122EE44.
- **SH and SW:** SH addr 0x0C, wdata 0xCAFE → word 3 = 0xCAFEEE44. SW addr 0x24, wdata 0xDEADBEEF → single write cycle 1, `mem_addr=9`, `resp_valid` cycle 2.
- **Misaligned:** LW 0x13, SH 0x05, LHU 0x01 → each gives `resp_valid=1` and `misaligned=1` in cycle 1, `mem_cs` never asserted, `rdata` unchanged.
- **Reset:** `rst` asserted in cycle 2 of SB addr 0x0E → no write cycle, no `resp_valid`, word 3 unchanged. All outputs 0 during reset; `req_ready=1` the cycle after `rst` falls.

Source files
------------

// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - shared constants, FSM states and request classification for the load/store unit
package ls_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 10;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        RESP
    } state_t;

    function automatic logic is_store(input logic [2:0] op);
        return op >= OP_SB;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return off != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ls_align.sv
// rtl/ls_align.sv - big-endian lane extraction/extension for loads and lane merge for sub-word stores
module ls_align
    import ls_pkg::*;
#(
    parameter int DATA_WIDTH = ls_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [1:0]            offset,
    input  logic [2:0]            op,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] store_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[7:0];
        case (offset)
            2'd0: byte_lane = word[31:24];
            2'd1: byte_lane = word[23:16];
            2'd2: byte_lane = word[15:8];
            2'd3: byte_lane = word[7:0];
            default: byte_lane = word[7:0];
        endcase
        half_lane = offset[1] ? word[15:0] : word[31:16];

        case (op)
            OP_LB:   load_data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            OP_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
            OP_LH:   load_data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            OP_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            default: load_data = word;
        endcase

        // Sub-word stores replace only their lane; anything else writes the whole word.
        store_data = word;
        case (op)
            OP_SB: begin
                case (offset)
                    2'd0: store_data[31:24] = wdata[7:0];
                    2'd1: store_data[23:16] = wdata[7:0];
                    2'd2: store_data[15:8]  = wdata[7:0];
                    default: store_data[7:0] = wdata[7:0];
                endcase
            end
            OP_SH: begin
                if (offset[1]) store_data[15:0]  = wdata[15:0];
                else           store_data[31:16] = wdata[15:0];
            end
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding MIPS load/store stage with read-modify-write sub-word stores
module load_store_unit
    import ls_pkg::*;
#(
    parameter int DATA_WIDTH = ls_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = ls_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            op,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  misaligned,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    state_t                state, state_next;
    logic                  accept;
    logic [2:0]            op_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  mis_q;
    logic [DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];
    assign accept           = req_valid && req_ready;

    ls_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .word       (mem_dout),
        .wdata      (wdata_q),
        .offset     (off_q),
        .op         (op_q),
        .load_data  (load_word),
        .store_data (merged_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            mis_q    <= 1'b0;
            rdata    <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q     <= op;
                off_q    <= addr[1:0];
                wdata_q  <= wdata;
                mis_q    <= is_misaligned(op, addr[1:0]);
                mem_addr <= addr[ADDR_WIDTH+1:2];
                if (op == OP_SW) mem_din <= wdata;
            end
            if (state == RWAIT) begin
                if (is_store(op_q)) mem_din <= merged_word;
                else                rdata   <= load_word;
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        misaligned = 1'b0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (accept) begin
                    if (is_misaligned(op, addr[1:0])) state_next = RESP;
                    else if (op == OP_SW)             state_next = WR;
                    else                              state_next = RD;
                end
            end
            RD: begin
                mem_cs     = 1'b1;
                state_next = RWAIT;
            end
            RWAIT: state_next = is_store(op_q) ? WR : RESP;
            WR: begin
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                misaligned = mis_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector table with response scoreboard and memory model for load_store_unit
module tb_load_store_unit;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          rd;
        int          wr;
        logic [9:0]  maddr;
        logic [31:0] din;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        misaligned;
    logic        mem_cs;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = '0;

    logic [31:0] mem [0:1023];
    int cyc = 0;
    int wr_cnt = 0;
    int acc = 0;
    int rd_seen = 0;
    int wr_seen = 0;
    logic [9:0]  rd_a, wr_a;
    logic [31:0] wr_d;
    int resp_total = 0;
    int checks = 0;
    int passes = 0;
    vec_t sb [$];
    vec_t vecs [$];

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .misaligned (misaligned),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_cs && mem_we) begin
            mem[mem_addr] <= mem_din;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_cs && !mem_we) mem_dout <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        vec_t e;
        if (mem_cs === 1'b1) begin
            if (mem_we) begin
                wr_seen = cyc - acc;
                wr_a = mem_addr;
                wr_d = mem_din;
            end else begin
                rd_seen = cyc - acc;
                rd_a = mem_addr;
            end
        end
        if (resp_valid === 1'b1) begin
            resp_total++;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                e = sb.pop_front();
                chk("resp_latency", cyc - acc, e.lat);
                chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
                chk("rdata", rdata, e.rdata);
                chk("read_cycle", rd_seen, e.rd);
                chk("write_cycle", wr_seen, e.wr);
                if (e.rd != 0) chk("read_addr", {22'b0, rd_a}, {22'b0, e.maddr});
                if (e.wr != 0) begin
                    chk("write_addr", {22'b0, wr_a}, {22'b0, e.maddr});
                    chk("write_data", wr_d, e.din);
                end
            end
        end
    end

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                                input logic [31:0] r, input logic m, input int l, input int rc,
                                input int wc, input logic [9:0] ma, input logic [31:0] d);
        vec_t v;
        v.op = o; v.addr = a; v.wdata = w; v.rdata = r; v.mis = m;
        v.lat = l; v.rd = rc; v.wr = wc; v.maddr = ma; v.din = d;
        return v;
    endfunction

    task automatic issue(input vec_t v, input bit score);
        int n;
        @(negedge clk);
        req_valid = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            chk("accept_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (score) sb.push_back(v);
        @(posedge clk);
        #1;
        acc = cyc - 1;
        rd_seen = 0;
        wr_seen = 0;
        req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("resp_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
        chk("rst_mem_cs", {31'b0, mem_cs}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
    endtask

    initial begin
        int wr_before;
        int resp_before;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[5] = 32'h8899AABB;
        mem[3] = 32'h11223344;
        rst = 1'b1; req_valid = 1'b0; op = '0; addr = '0; wdata = '0;

        //        op    addr          wdata         rdata         mis lat rd wr maddr din
        vecs.push_back(mk(3'd2, 32'h14, 32'h0, 32'h8899AABB, 0, 3, 1, 0, 10'd5, 32'h0));
        vecs.push_back(mk(3'd0, 32'h15, 32'h0, 32'hFFFFFF99, 0, 3, 1, 0, 10'd5, 32'h0));
        vecs.push_back(mk(3'd3, 32'h15, 32'h0, 32'h00000099, 0, 3, 1, 0, 10'd5, 32'h0));
        vecs.push_back(mk(3'd1, 32'h16, 32'h0, 32'hFFFFAABB, 0, 3, 1, 0, 10'd5, 32'h0));
        vecs.push_back(mk(3'd4, 32'h14, 32'h0, 32'h00008899, 0, 3, 1, 0, 10'd5, 32'h0));
        vecs.push_back(mk(3'd0, 32'h17, 32'h0, 32'hFFFFFFBB, 0, 3, 1, 0, 10'd5, 32'h0));
        vecs.push_back(mk(3'd3, 32'h14, 32'h0, 32'h00000088, 0, 3, 1, 0, 10'd5, 32'h0));
        vecs.push_back(mk(3'd5, 32'h0E, 32'h000000EE, 32'h00000088, 0, 4, 1, 3, 10'd3, 32'h1122EE44));
        vecs.push_back(mk(3'd2, 32'h0C, 32'h0, 32'h1122EE44, 0, 3, 1, 0, 10'd3, 32'h0));
        vecs.push_back(mk(3'd6, 32'h0C, 32'h0000CAFE, 32'h1122EE44, 0, 4, 1, 3, 10'd3, 32'hCAFEEE44));
        vecs.push_back(mk(3'd2, 32'h0C, 32'h0, 32'hCAFEEE44, 0, 3, 1, 0, 10'd3, 32'h0));
        vecs.push_back(mk(3'd7, 32'h24, 32'hDEADBEEF, 32'hCAFEEE44, 0, 2, 0, 1, 10'd9, 32'hDEADBEEF));
        vecs.push_back(mk(3'd2, 32'h24, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0, 10'd9, 32'h0));
        vecs.push_back(mk(3'd2, 32'h13, 32'h0, 32'hDEADBEEF, 1, 1, 0, 0, 10'd0, 32'h0));
        vecs.push_back(mk(3'd6, 32'h05, 32'h1234, 32'hDEADBEEF, 1, 1, 0, 0, 10'd0, 32'h0));
        vecs.push_back(mk(3'd4, 32'h01, 32'h0, 32'hDEADBEEF, 1, 1, 0, 0, 10'd0, 32'h0));
        vecs.push_back(mk(3'd5, 32'h27, 32'h12345678, 32'hDEADBEEF, 0, 4, 1, 3, 10'd9, 32'hDEADBE78));
        vecs.push_back(mk(3'd1, 32'h24, 32'h0, 32'hFFFFDEAD, 0, 3, 1, 0, 10'd9, 32'h0));
        vecs.push_back(mk(3'd7, 32'hFFFFF028, 32'h0BADF00D, 32'hFFFFDEAD, 0, 2, 0, 1, 10'd10, 32'h0BADF00D));
        vecs.push_back(mk(3'd2, 32'h28, 32'h0, 32'h0BADF00D, 0, 3, 1, 0, 10'd10, 32'h0));
        vecs.push_back(mk(3'd1, 32'h2A, 32'h0, 32'hFFFFF00D, 0, 3, 1, 0, 10'd10, 32'h0));
        vecs.push_back(mk(3'd4, 32'h2A, 32'h0, 32'h0000F00D, 0, 3, 1, 0, 10'd10, 32'h0));
        vecs.push_back(mk(3'd5, 32'h28, 32'h00000080, 32'h0000F00D, 0, 4, 1, 3, 10'd10, 32'h80ADF00D));
        vecs.push_back(mk(3'd0, 32'h28, 32'h0, 32'hFFFFFF80, 0, 3, 1, 0, 10'd10, 32'h0));

        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;

        foreach (vecs[i]) issue(vecs[i], 1'b1);

        // Reset arriving while an SB is between its read and its write.
        wr_before = wr_cnt;
        resp_before = resp_total;
        issue(mk(3'd5, 32'h0E, 32'h00000011, 32'h0, 0, 4, 1, 3, 10'd3, 32'h0), 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_write", wr_cnt, wr_before);
        chk("abort_no_resp", resp_total, resp_before);
        chk("abort_word3", mem[3], 32'hCAFEEE44);
        chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

        issue(mk(3'd2, 32'h0C, 32'h0, 32'hCAFEEE44, 0, 3, 1, 0, 10'd3, 32'h0), 1'b1);
        issue(mk(3'd2, 32'h01, 32'h0, 32'hCAFEEE44, 1, 1, 0, 0, 10'd0, 32'h0), 1'b1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
